// File: rtl/cordic_pkg.sv
// Shared constants, arctangent table and Q2.14 helpers for the iterative CORDIC datapath.
package cordic_pkg;

  localparam int W     = 16;
  localparam int N_ITR = 16;
  localparam int GW    = 2;
  localparam int IW    = W + GW;
  localparam int ITR_W = $clog2(N_ITR);

  localparam logic signed [W-1:0] CORDIC_INV_K = 16'sd9949;

  // round(atan(2^-i) * 2^14), ties away from zero
  localparam logic signed [W-1:0] ATAN [N_ITR] = '{
    16'sd12868, 16'sd7596, 16'sd4014, 16'sd2037, 16'sd1023, 16'sd512, 16'sd256, 16'sd128,
    16'sd64,    16'sd32,   16'sd16,   16'sd8,    16'sd4,    16'sd2,   16'sd1,   16'sd1
  };

  function automatic logic signed [IW-1:0] sext(input logic signed [W-1:0] v);
    return {{GW{v[W-1]}}, v};
  endfunction

  // Clamp an internal value into the signed W-bit output range.
  function automatic logic signed [W-1:0] sat(input logic signed [IW-1:0] v);
    if (!v[IW-1] && (|v[IW-2:W-1]))       return {1'b0, {(W-1){1'b1}}};
    else if (v[IW-1] && !(&v[IW-2:W-1]))  return {1'b1, {(W-1){1'b0}}};
    else                                  return v[W-1:0];
  endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Combinational arctangent lookup: iteration index -> ATAN[i] in Q2.14 radians.
module cordic_atan_rom
  import cordic_pkg::*;
(
  input  logic [ITR_W-1:0]    idx,
  output logic signed [W-1:0] atan
);

  assign atan = ATAN[idx];

endmodule

// File: rtl/cordic_dp.sv
// Rotation-mode CORDIC datapath: one micro-rotation per ld, result captured on fin.
module cordic_dp
  import cordic_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                init,
  input  logic                ld,
  input  logic                fin,
  input  logic [W-1:0]        x_in,
  input  logic [W-1:0]        y_in,
  input  logic [W-1:0]        z_in,
  output logic [ITR_W-1:0]    itr,
  output logic [W-1:0]        x_out,
  output logic [W-1:0]        y_out,
  output logic [W-1:0]        z_out,
  output logic                rdy
);

  logic signed [IW-1:0] x_q, x_d, y_q, y_d;
  logic signed [W-1:0]  z_q, z_d;
  logic [ITR_W-1:0]     itr_q, itr_d;
  logic signed [W-1:0]  x_out_q, x_out_d, y_out_q, y_out_d, z_out_q, z_out_d;
  logic                 rdy_q, rdy_d;

  logic signed [W-1:0]  atan_val;
  logic signed [IW-1:0] x_sh, y_sh;

  cordic_atan_rom u_atan_rom (
    .idx  (itr_q),
    .atan (atan_val)
  );

  assign x_sh = x_q >>> itr_q;
  assign y_sh = y_q >>> itr_q;

  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latch).
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    itr_d   = itr_q;
    x_out_d = x_out_q;
    y_out_d = y_out_q;
    z_out_d = z_out_q;
    rdy_d   = rdy_q;

    if (init) begin
      x_d   = sext(x_in);
      y_d   = sext(y_in);
      z_d   = z_in;
      itr_d = '0;
      rdy_d = 1'b0;
    end else begin
      if (ld) begin
        if (!z_q[W-1]) begin
          x_d = x_q - y_sh;
          y_d = y_q + x_sh;
          z_d = z_q - atan_val;
        end else begin
          x_d = x_q + y_sh;
          y_d = y_q - x_sh;
          z_d = z_q + atan_val;
        end
        itr_d = itr_q + ITR_W'(1);
      end
      if (fin) begin
        x_out_d = sat(x_q);
        y_out_d = sat(y_q);
        z_out_d = z_q;
        rdy_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      itr_q   <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
      z_out_q <= '0;
      rdy_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values simultaneously.
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      itr_q   <= itr_d;
      x_out_q <= x_out_d;
      y_out_q <= y_out_d;
      z_out_q <= z_out_d;
      rdy_q   <= rdy_d;
    end
  end

  assign itr   = itr_q;
  assign x_out = x_out_q;
  assign y_out = y_out_q;
  assign z_out = z_out_q;
  assign rdy   = rdy_q;

endmodule

// File: tb/tb_cordic_dp.sv
// Self-checking bench for cordic_dp: directed vector table, handshake corner cases, random runs vs a reference model.
module tb_cordic_dp;

  logic        clk = 1'b0;
  logic        rst, init, ld, fin;
  logic [15:0] x_in, y_in, z_in;
  logic [3:0]  itr;
  logic [15:0] x_out, y_out, z_out;
  logic        rdy;

  int n_checks = 0;
  int n_fail   = 0;

  int atan_t [16] = '{12868, 7596, 4014, 2037, 1023, 512, 256, 128, 64, 32, 16, 8, 4, 2, 1, 1};

  typedef struct {
    int x_in, y_in, z_in;
    int exp_x, tol_x;
    int exp_y, tol_y;
    int exp_z, tol_z;
  } vec_t;

  cordic_dp dut (
    .clk   (clk),
    .rst   (rst),
    .init  (init),
    .ld    (ld),
    .fin   (fin),
    .x_in  (x_in),
    .y_in  (y_in),
    .z_in  (z_in),
    .itr   (itr),
    .x_out (x_out),
    .y_out (y_out),
    .z_out (z_out),
    .rdy   (rdy)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached (got timeout, need completion)");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d", name, act, exp);
    end
  endtask

  task automatic check_tol(input string name, input int act, input int exp, input int tol);
    n_checks++;
    if (act < exp - tol || act > exp + tol) begin
      n_fail++;
      $display("FAIL %s: got %0d, need %0d +- %0d", name, act, exp, tol);
    end
  endtask

  function automatic int clamp16(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Algorithmic reference: 16 CORDIC rotations on plain integers, then output saturation.
  task automatic model(input int xi, input int yi, input int zi,
                       output int xo, output int yo, output int zo);
    int x, y, z, xs, ys;
    x = xi; y = yi; z = zi;
    for (int i = 0; i < 16; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (z >= 0) begin
        x = x - ys; y = y + xs; z = z - atan_t[i];
      end else begin
        x = x + ys; y = y - xs; z = z + atan_t[i];
      end
    end
    xo = clamp16(x);
    yo = clamp16(y);
    zo = z;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int s16(input logic [15:0] v);
    return int'($signed(v));
  endfunction

  // Controller sequence: init+ld, ld x16 (optional 3-cycle pause after gap_at lds), fin.
  task automatic run(input int xi, input int yi, input int zi, input int gap_at, input string tag);
    x_in = 16'(xi); y_in = 16'(yi); z_in = 16'(zi);
    init = 1'b1; ld = 1'b1; fin = 1'b0;
    step();
    check({tag, " itr after init"}, int'(itr), 0);
    check({tag, " rdy after init"}, int'(rdy), 0);
    init = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == gap_at) begin
        ld = 1'b0;
        for (int g = 0; g < 3; g++) begin
          step();
          check({tag, " itr hold in gap"}, int'(itr), i);
        end
      end
      ld = 1'b1;
      check({tag, " itr during ld"}, int'(itr), i);
      step();
    end
    ld = 1'b0;
    check({tag, " itr wrap"}, int'(itr), 0);
    check({tag, " rdy before fin"}, int'(rdy), 0);
    fin = 1'b1;
    step();
    fin = 1'b0;
    check({tag, " rdy after fin"}, int'(rdy), 1);
  endtask

  initial begin
    vec_t vecs [4];
    int mx, my, mz;

    vecs[0] = '{9949, 0, 0,          16384, 4,  0,     4, 0, 2};
    vecs[1] = '{9949, 0, 12868,      11585, 4,  11585, 4, 0, 2};
    vecs[2] = '{9949, 0, -25736,     0,     4, -16384, 4, 0, 2};
    vecs[3] = '{32767, 32767, 12868, 0,     8,  32767, 0, 0, 2};

    rst = 1'b1; init = 1'b0; ld = 1'b0; fin = 1'b0;
    x_in = '0; y_in = '0; z_in = '0;
    step(); step();
    check("reset itr", int'(itr), 0);
    check("reset rdy", int'(rdy), 0);
    check("reset x_out", s16(x_out), 0);
    rst = 1'b0;

    // Reset mid-run
    x_in = 16'd9949; y_in = '0; z_in = '0;
    init = 1'b1; ld = 1'b1;
    step();
    init = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("midrun itr before rst", int'(itr), 5);
    ld = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    check("midrun rst itr", int'(itr), 0);
    check("midrun rst rdy", int'(rdy), 0);
    check("midrun rst x_out", s16(x_out), 0);
    check("midrun rst y_out", s16(y_out), 0);
    check("midrun rst z_out", s16(z_out), 0);
    ld = 1'b1;
    for (int i = 0; i < 16; i++) step();
    ld = 1'b0; fin = 1'b1;
    step();
    fin = 1'b0;
    check("post-rst ld x_out", s16(x_out), 0);
    check("post-rst ld y_out", s16(y_out), 0);
    check("post-rst ld rdy", int'(rdy), 1);

    // Directed vector table
    foreach (vecs[k]) begin
      run(vecs[k].x_in, vecs[k].y_in, vecs[k].z_in, -1, $sformatf("vec%0d", k));
      check_tol($sformatf("vec%0d x_out", k), s16(x_out), vecs[k].exp_x, vecs[k].tol_x);
      check_tol($sformatf("vec%0d y_out", k), s16(y_out), vecs[k].exp_y, vecs[k].tol_y);
      check_tol($sformatf("vec%0d z_out", k), s16(z_out), vecs[k].exp_z, vecs[k].tol_z);
      model(vecs[k].x_in, vecs[k].y_in, vecs[k].z_in, mx, my, mz);
      check($sformatf("vec%0d x_out model", k), s16(x_out), mx);
      check($sformatf("vec%0d y_out model", k), s16(y_out), my);
      check($sformatf("vec%0d z_out model", k), s16(z_out), mz);
    end

    // rdy stays high while idle after fin
    step(); step();
    check("rdy held idle", int'(rdy), 1);

    // ld paused for 3 cycles mid-run gives the same answer as an uninterrupted run
    run(9949, 0, 12868, 7, "gap");
    model(9949, 0, 12868, mx, my, mz);
    check("gap x_out", s16(x_out), mx);
    check("gap y_out", s16(y_out), my);
    check("gap z_out", s16(z_out), mz);

    // init coinciding with fin: init wins, registers reload
    x_in = 16'd9949; y_in = '0; z_in = 16'(-12868);
    init = 1'b1; fin = 1'b1; ld = 1'b0;
    step();
    init = 1'b0; fin = 1'b0;
    check("init+fin rdy", int'(rdy), 0);
    check("init+fin itr", int'(itr), 0);
    x_in = '0; y_in = '0; z_in = '0;
    ld = 1'b1;
    for (int i = 0; i < 16; i++) step();
    ld = 1'b0; fin = 1'b1;
    step();
    fin = 1'b0;
    model(9949, 0, -12868, mx, my, mz);
    check("init+fin reload x_out", s16(x_out), mx);
    check("init+fin reload y_out", s16(y_out), my);
    check("init+fin reload rdy", int'(rdy), 1);

    // Randomised runs against the reference model
    for (int r = 0; r < 24; r++) begin
      int xi, yi, zi;
      xi = int'($urandom_range(32000)) - 16000;
      yi = int'($urandom_range(32000)) - 16000;
      zi = int'($urandom_range(51472)) - 25736;
      run(xi, yi, zi, (r % 3 == 0) ? int'($urandom_range(15)) : -1, "rand");
      model(xi, yi, zi, mx, my, mz);
      check($sformatf("rand%0d x_out", r), s16(x_out), mx);
      check($sformatf("rand%0d y_out", r), s16(y_out), my);
      check($sformatf("rand%0d z_out", r), s16(z_out), mz);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
